// File: rtl/vedic_seq_mult_if.sv
// Start/done multiply handshake: operands in, busy/done/product out.
// master drives the request side; slave is the multiplier.
interface vedic_seq_mult_if #(
    parameter int N = 8
);
    logic           start;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic           busy;
    logic           done;
    logic [2*N-1:0] P;

    modport master (output start, A, B, input busy, done, P);
    modport slave  (input start, A, B, output busy, done, P);
endinterface

// File: rtl/vedic_seq_mult.sv
// Sequential NxN Urdhva-Tiryagbhyam multiplier: one product column per clock.
// Latency 2N-1 edges from accepted start to done; start is ignored while busy.
module vedic_seq_mult #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    vedic_seq_mult_if.slave  bus
);
    localparam int CLW = $clog2(2*N);
    localparam int CW  = CLW + 1;
    localparam logic [CLW-1:0] LAST_COL = CLW'(2*N-2);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [CLW-1:0] r_col;
    logic [CW-2:0]  r_carry;
    logic [2*N-3:0] r_acc;
    logic [2*N-1:0] r_p;
    logic           r_busy;
    logic           r_done;

    logic [N-1:0]   w_pp;
    logic [CW-1:0]  w_colsum;
    logic [CW-2:0]  w_carry_nxt;
    logic           w_last;
    logic           w_accept;

    // Row i of the partial-product array is b shifted by i; bit col of that row
    // pairs a[i] with b[col-i], and is zero outside the valid crosswise range.
    for (genvar gi = 0; gi < N; gi++) begin : g_pp
        logic [2*N-1:0] w_row;
        assign w_row     = {{N{1'b0}}, r_b} << gi;
        assign w_pp[gi]  = r_a[gi] & w_row[r_col];
    end

    assign w_colsum    = CW'(r_carry) + CW'($countones(w_pp));
    assign w_carry_nxt = w_colsum[CW-1:1];
    assign w_last      = (r_col == LAST_COL);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CALC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_col   <= '0;
            r_carry <= '0;
            r_acc   <= '0;
            r_p     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == CALC);
            r_done  <= (w_state_nxt == DONE);
            if (w_accept) begin
                r_a     <= bus.A;
                r_b     <= bus.B;
                r_col   <= '0;
                r_carry <= '0;
                r_acc   <= '0;
            end else if (r_state == CALC) begin
                r_col   <= r_col + CLW'(1);
                r_carry <= w_carry_nxt;
                // Shifting in from the top leaves column k at bit k after 2N-2 columns.
                r_acc   <= {w_colsum[0], r_acc[2*N-3:1]};
                if (w_last) begin
                    r_p <= {w_carry_nxt[0], w_colsum[0], r_acc};
                end
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.P    = r_p;

    // The product fits in 2N bits, so the last column can carry at most one.
    a_final_carry: assert property (@(posedge clk) disable iff (rst)
        (r_state == CALC && w_last) |-> (w_colsum[CW-1:2] == '0));
endmodule

// File: tb/tb_vedic_seq_mult.sv
// Randomised and directed bench for vedic_seq_mult at N=8 and N=4.
// Expected products come from plain A*B and a start/done timing model.
module tb_vedic_seq_mult;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit go_rand  = 1'b0;
    bit rand_fin [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int NN = (g == 0) ? 8 : 4;

        vedic_seq_mult_if #(.N(NN)) bus ();
        vedic_seq_mult #(.N(NN)) dut (.clk(clk), .rst(rst), .bus(bus));

        typedef struct {
            logic [2*NN-1:0] p;
            longint          edge_n;
        } exp_t;

        exp_t            q[$];
        longint          cyc    = 0;
        longint          t_acc  = -1000;
        int              n_acc  = 0;
        logic [2*NN-1:0] last_p = '0;

        // Reference: a request is taken when start is seen and the previous
        // operation accepted at t_acc has reached its done cycle (t_acc+2N).
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                q.delete();
                t_acc  = -1000;
                last_p = '0;
            end else begin
                cyc++;
                if (bus.start && cyc >= t_acc + 2*NN) begin
                    t_acc = cyc;
                    n_acc++;
                    q.push_back('{p: (2*NN)'(bus.A) * (2*NN)'(bus.B), edge_n: cyc + 2*NN - 1});
                end
            end
        end

        always @(negedge clk) begin
            logic exp_done;
            if (!rst) begin
                exp_done = (q.size() > 0) && (q[0].edge_n == cyc);
                check($sformatf("busy_n%0d", NN), bus.busy, (cyc - t_acc) <= 2*NN - 2);
                check($sformatf("done_n%0d", NN), bus.done, exp_done);
                if (exp_done) begin
                    check($sformatf("product_n%0d", NN), bus.P, q[0].p);
                    last_p = q[0].p;
                    void'(q.pop_front());
                end else begin
                    check($sformatf("p_hold_n%0d", NN), bus.P, last_p);
                end
            end
        end

        initial begin
            bus.start = 1'b0;
            bus.A     = '0;
            bus.B     = '0;
            wait (go_rand);
            for (int c = 0; c < 40000 && n_acc < 1000; c++) begin
                @(negedge clk);
                bus.start = ($urandom_range(0, 3) != 0);
                bus.A     = NN'($urandom);
                bus.B     = NN'($urandom);
            end
            @(negedge clk);
            bus.start = 1'b0;
            for (int c = 0; c < 4*NN && q.size() > 0; c++) @(negedge clk);
            check($sformatf("rand_count_n%0d", NN), n_acc >= 1000, 1);
            check($sformatf("rand_drain_n%0d", NN), q.size(), 0);
            rand_fin[g] = 1'b1;
        end
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        g_dut[0].bus.start = 1'b1;
        g_dut[0].bus.A     = a;
        g_dut[0].bus.B     = b;
        @(negedge clk);
        g_dut[0].bus.start = 1'b0;
        g_dut[0].bus.A     = 8'($urandom);
        g_dut[0].bus.B     = 8'($urandom);
    endtask

    task automatic wait_done8(output int nbusy);
        bit seen;
        seen  = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            #1;
            if (g_dut[0].bus.busy) nbusy++;
            if (g_dut[0].bus.done) seen = 1'b1;
            else @(negedge clk);
        end
        check("done_within_budget", seen, 1);
    endtask

    task automatic count_dones8(input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            #1;
            if (g_dut[0].bus.done) n++;
        end
    endtask

    initial begin
        int     nb;
        int     nd;
        longint t1;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy8", g_dut[0].bus.busy, 0);
        check("rst_done8", g_dut[0].bus.done, 0);
        check("rst_p8",    g_dut[0].bus.P, 0);
        check("rst_p4",    g_dut[1].bus.P, 0);
        @(negedge clk);
        rst = 1'b0;

        issue8(8'h0D, 8'h0B);
        wait_done8(nb);
        check("basic_busy_cycles", nb, 15);
        check("basic_p", g_dut[0].bus.P, 16'h008F);

        issue8(8'hFF, 8'hFF);
        wait_done8(nb);
        check("max_p", g_dut[0].bus.P, 16'hFE01);

        issue8(8'h00, 8'hA5);
        wait_done8(nb);
        check("zero_p", g_dut[0].bus.P, 16'h0000);
        issue8(8'h01, 8'hA5);
        wait_done8(nb);
        check("ident_p", g_dut[0].bus.P, 16'h00A5);

        issue8(8'h12, 8'h34);
        repeat (4) @(negedge clk);
        issue8(8'hFF, 8'hFF);
        wait_done8(nb);
        check("ignored_start_p", g_dut[0].bus.P, 16'h03A8);
        count_dones8(20, nd);
        check("ignored_start_single_done", nd, 0);

        @(negedge clk);
        g_dut[0].bus.start = 1'b1;
        g_dut[0].bus.A     = 8'h0D;
        g_dut[0].bus.B     = 8'h0B;
        @(negedge clk);
        g_dut[0].bus.A     = 8'h80;
        g_dut[0].bus.B     = 8'h02;
        wait_done8(nb);
        check("b2b_first_p", g_dut[0].bus.P, 16'h008F);
        t1 = $time;
        @(negedge clk);
        g_dut[0].bus.start = 1'b0;
        wait_done8(nb);
        check("b2b_spacing", ($time - t1) / 10, 16);
        check("b2b_second_p", g_dut[0].bus.P, 16'h0100);

        issue8(8'h55, 8'h66);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", g_dut[0].bus.busy, 0);
        check("midrst_done", g_dut[0].bus.done, 0);
        check("midrst_p",    g_dut[0].bus.P, 0);
        @(negedge clk);
        rst = 1'b0;
        count_dones8(24, nd);
        check("midrst_no_done", nd, 0);
        issue8(8'h07, 8'h09);
        wait_done8(nb);
        check("after_rst_p", g_dut[0].bus.P, 16'h003F);

        go_rand = 1'b1;
        wait (rand_fin[0] && rand_fin[1]);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
